// File: rtl/freq_glide_ctrl.sv
// NCO front-end control: synchronises and debounces the board switches, forms the
// phase-increment word SW[14:4] << SW[3:0], and optionally slews toward each new word.
module freq_glide_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned GLIDE_DIV   = 1000,
  parameter int unsigned GLIDE_SHIFT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sw_in,
  input  logic        glide_en,
  output logic [31:0] ctrl_out,
  output logic        sel_sin,
  output logic        settled
);

  localparam int unsigned DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int unsigned PRE_W = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(GLIDE_DIV - 1);

  typedef enum logic {
    IDLE,
    GLIDE
  } state_e;

  logic [15:0]      sync1_q, sync2_q;
  logic [15:0]      stable_q, stable_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic [PRE_W-1:0] pre_q;
  logic             tick;
  state_e           state_q;
  logic [31:0]      ctrl_q;
  logic             settled_q;

  logic [31:0] target, target_nxt;
  logic        up;
  logic [31:0] diff, step_raw, step, glide_val;

  function automatic logic [31:0] word_of(input logic [15:0] s);
    return {21'b0, s[14:4]} << s[3:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sw_in;
      sync2_q <= sync1_q;
    end
  end

  // NOTE: defaults at the top of always_comb keep every path assigned, so no latch is inferred.
  always_comb begin
    stable_d  = stable_q;
    deb_cnt_d = '0;
    if (sync2_q != stable_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        stable_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q  <= '0;
      deb_cnt_q <= '0;
    end else begin
      stable_q  <= stable_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q <= '0;
    end else begin
      pre_q <= tick ? '0 : pre_q + PRE_W'(1);
    end
  end

  assign tick       = (pre_q == PRE_LAST);
  assign target     = word_of(stable_q);
  // settled is registered against the target that will be in force after this edge.
  assign target_nxt = word_of(stable_d);

  assign up        = (target > ctrl_q);
  assign diff      = up ? (target - ctrl_q) : (ctrl_q - target);
  assign step_raw  = diff >> GLIDE_SHIFT;
  assign step      = (step_raw == '0) ? 32'd1 : step_raw;
  assign glide_val = up ? (ctrl_q + step) : (ctrl_q - step);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      settled_q <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (target != ctrl_q) begin
            if (!glide_en) begin
              ctrl_q    <= target;
              settled_q <= (target == target_nxt);
            end else begin
              state_q   <= GLIDE;
              settled_q <= 1'b0;
            end
          end else begin
            settled_q <= (ctrl_q == target_nxt);
          end
        end
        GLIDE: begin
          if (!glide_en) begin
            state_q   <= IDLE;
            ctrl_q    <= target;
            settled_q <= (target == target_nxt);
          end else if (target == ctrl_q) begin
            state_q   <= IDLE;
            settled_q <= (ctrl_q == target_nxt);
          end else if (tick) begin
            ctrl_q <= glide_val;
            if (glide_val == target) begin
              state_q   <= IDLE;
              settled_q <= (glide_val == target_nxt);
            end else begin
              settled_q <= 1'b0;
            end
          end else begin
            settled_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= IDLE;
          settled_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_out = ctrl_q;
  assign sel_sin  = stable_q[15];
  assign settled  = settled_q;

endmodule

// File: tb/tb_freq_glide_ctrl.sv
// Self-checking bench for freq_glide_ctrl: directed scenarios plus randomized
// switch/glide activity compared cycle by cycle against an arithmetic reference model.
module tb_freq_glide_ctrl;

  localparam int DEB = 4;
  localparam int DIV = 2;
  localparam int SH  = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] sw;
  logic        gen;
  logic [31:0] ctrl;
  logic        sel;
  logic        settled;

  int n_checks = 0;
  int n_fail   = 0;

  freq_glide_ctrl #(
    .DEB_CYCLES (DEB),
    .GLIDE_DIV  (DIV),
    .GLIDE_SHIFT(SH)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .sw_in   (sw),
    .glide_en(gen),
    .ctrl_out(ctrl),
    .sel_sin (sel),
    .settled (settled)
  );

  always #5 clk = ~clk;

  // Reference model state: switch history, accepted switches, output word.
  logic [15:0] m_hist [2];
  logic [15:0] m_stable;
  int          m_cnt;
  longint      m_ctrl;
  bit          m_gliding;
  longint      m_edges;

  function automatic longint target_of(input logic [15:0] s);
    return longint'(s[14:4]) * (longint'(1) << s[3:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_hist[0] = '0;
    m_hist[1] = '0;
    m_stable  = '0;
    m_cnt     = 0;
    m_ctrl    = 0;
    m_gliding = 1'b0;
    m_edges   = 0;
  endtask

  task automatic model_step(input logic [15:0] s, input logic g);
    longint tgt;
    longint d;
    longint st;
    bit     tck;
    tgt = target_of(m_stable);
    tck = ((m_edges % DIV) == DIV - 1);
    m_edges++;
    if (!m_gliding) begin
      if (tgt != m_ctrl) begin
        if (!g) m_ctrl = tgt;
        else    m_gliding = 1'b1;
      end
    end else if (!g) begin
      m_ctrl    = tgt;
      m_gliding = 1'b0;
    end else if (tgt == m_ctrl) begin
      m_gliding = 1'b0;
    end else if (tck) begin
      d  = (tgt > m_ctrl) ? tgt - m_ctrl : m_ctrl - tgt;
      st = d >> SH;
      if (st < 1) st = 1;
      m_ctrl = (tgt > m_ctrl) ? m_ctrl + st : m_ctrl - st;
      if (m_ctrl == tgt) m_gliding = 1'b0;
    end
    // Debounce works on the value that reached the far end of the 2-flop chain.
    if (m_hist[1] == m_stable) begin
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == DEB) begin
        m_stable = m_hist[1];
        m_cnt    = 0;
      end
    end
    m_hist[1] = m_hist[0];
    m_hist[0] = s;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(sw, gen);
    #1;
    check("ctrl_model", ctrl, 32'(m_ctrl));
    check("sel_model", 32'(sel), 32'(m_stable[15]));
    check("settled_model", 32'(settled),
          32'(!m_gliding && (m_ctrl == target_of(m_stable))));
  endtask

  int unsigned glide_exp [11] = '{5, 8, 11, 13, 14, 15, 16, 17, 18, 19, 20};

  initial begin
    int          idx;
    int          t;
    int          hold;
    int          settle_low;
    logic [31:0] prev;
    logic [31:0] min_seen;

    // 1: reset with all switches on, then full acquisition.
    reset_n = 1'b0;
    sw      = 16'hFFFF;
    gen     = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", ctrl, 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_settled", 32'(settled), 32'h1);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (k == 5) check("acq_sel_before", 32'(sel), 32'h0);
      if (k == 6) begin
        check("acq_sel_c6", 32'(sel), 32'h1);
        check("acq_ctrl_c6", ctrl, 32'h0);
      end
      if (k == 7) check("acq_ctrl_c7", ctrl, 32'h03FF_8000);
    end

    // 2: snap 0 -> 0x00A1 lands exactly 7 cycles after the switch edge.
    sw = 16'h0000;
    repeat (8) cycle();
    sw = 16'h00A1;
    settle_low = 0;
    for (int k = 1; k <= 7; k++) begin
      cycle();
      if (!settled) settle_low++;
      if (k == 6) check("snap_ctrl_c6", ctrl, 32'd0);
      if (k == 7) check("snap_ctrl_c7", ctrl, 32'd20);
    end
    check("snap_settle_drop_le1", 32'(settle_low <= 1), 32'h1);

    // 3: a 3-cycle bounce on bit 5 is rejected.
    sw = 16'h00A1 ^ 16'h0020;
    repeat (3) cycle();
    sw = 16'h00A1;
    repeat (8) cycle();
    check("bounce_ctrl", ctrl, 32'd20);
    check("bounce_sel", 32'(sel), 32'h0);
    check("bounce_settled", 32'(settled), 32'h1);

    // 4: glide 0 -> 20 with the expected step sequence.
    sw = 16'h0000;
    repeat (8) cycle();
    gen  = 1'b1;
    sw   = 16'h00A1;
    idx  = 0;
    t    = 0;
    prev = ctrl;
    while (idx < 11 && t < 200) begin
      cycle();
      t++;
      if (ctrl != prev) begin
        check("glide_seq", ctrl, glide_exp[idx]);
        idx++;
        prev = ctrl;
      end
    end
    check("glide_steps_seen", 32'(idx), 32'd11);
    check("glide_settled_at_20", 32'(settled), 32'h1);

    // 5: retarget mid-glide at 11 toward 4, then a snap out of a fresh glide.
    gen = 1'b0;
    sw  = 16'h0000;
    repeat (8) cycle();
    gen = 1'b1;
    sw  = 16'h00A1;
    t   = 0;
    while (ctrl != 32'd11 && t < 200) begin
      cycle();
      t++;
    end
    check("reach_11", ctrl, 32'd11);
    sw       = 16'h0021;
    t        = 0;
    min_seen = ctrl;
    while (!(ctrl == 32'd4 && settled) && t < 300) begin
      cycle();
      t++;
      if (ctrl < min_seen) min_seen = ctrl;
    end
    check("retarget_final", ctrl, 32'd4);
    check("retarget_no_restart", min_seen, 32'd4);
    sw = 16'h00A1;
    t  = 0;
    while (ctrl == 32'd4 && t < 100) begin
      cycle();
      t++;
    end
    check("new_glide_started", 32'(ctrl != 32'd4 && ctrl != 32'd20), 32'h1);
    gen = 1'b0;
    cycle();
    check("glide_abort_snap", ctrl, 32'd20);
    check("glide_abort_settled", 32'(settled), 32'h1);

    // 6: sine/cosine select only.
    sw = 16'h80A1;
    for (int k = 1; k <= 6; k++) begin
      cycle();
      check("sel_ctrl_hold", ctrl, 32'd20);
      check("sel_settled_hold", 32'(settled), 32'h1);
      if (k == 5) check("sel_c5", 32'(sel), 32'h0);
      if (k == 6) check("sel_c6", 32'(sel), 32'h1);
    end

    // 7: randomized switches, glide enable and bounces, with a mid-run reset.
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        case ($urandom_range(0, 3))
          0: sw = 16'($urandom);
          1: sw = {1'($urandom), 11'($urandom_range(0, 63)), 4'($urandom_range(0, 3))};
          2: sw = sw ^ (16'h1 << $urandom_range(0, 15));
          default: sw = {1'($urandom), 11'($urandom), 4'($urandom_range(0, 15))};
        endcase
        hold = $urandom_range(1, 40);
      end
      hold--;
      if ($urandom_range(0, 39) == 0) gen = ~gen;
      if (i == 1500) begin
        reset_n = 1'b0;
        #1;
        check("midrst_ctrl", ctrl, 32'h0);
        check("midrst_sel", 32'(sel), 32'h0);
        check("midrst_settled", 32'(settled), 32'h1);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
